ttc_cmd_scheduler: RTL



---
 rtl/ttc_cmd_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ttc_cmd_scheduler.sv
// ttc_cmd_scheduler
//   Builds the 16-bit frame stream for the TTC/command serializer at 160 MHz
//   (4 cycles per bunch crossing). Per-BX trigger hits are packed into tagged
//   trigger frames and queued. Host command words are interleaved with them,
//   periodic sync frames are forced in, and idle slots are filled with NOOP.
// Ports
//   clk160        : 160 MHz clock
//   rst           : asynchronous active-low reset
//   trig          : trigger hit, sampled every cycle
//   cmd_valid/cmd_data/cmd_ready : host command word handshake (ready is combinational)
//   frame_valid/frame_data/frame_ready : frame handshake to the serializer
//   bx_phase      : position within the current BX (0..3)
//   trig_drop_cnt : saturating count of trigger patterns lost to a full queue
module ttc_cmd_scheduler #(
  parameter int unsigned SYNC_INTERVAL = 32,
  parameter int unsigned TRIG_DEPTH    = 4,
  parameter logic [15:0] SYNC_WORD     = 16'h817E,
  parameter logic [15:0] NOOP_WORD     = 16'h6969
) (
  input  logic        clk160,
  input  logic        rst,
  input  logic        trig,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_data,
  output logic        cmd_ready,
  output logic        frame_valid,
  output logic [15:0] frame_data,
  input  logic        frame_ready,
  output logic [1:0]  bx_phase,
  output logic [7:0]  trig_drop_cnt
);

  localparam int unsigned AW = $clog2(TRIG_DEPTH);

  typedef struct packed {
    logic [3:0] pat;
    logic [7:0] tag;
  } trig_ent_t;

  logic [1:0]  phase_q;
  logic [3:0]  pat_q;
  logic [7:0]  tag_q;
  logic [7:0]  drop_q;
  logic [7:0]  sync_cnt_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fvalid_q;
  logic [15:0] fdata_q;
  trig_ent_t   fifo_q [TRIG_DEPTH];

  logic        xfer, q_empty, q_full, sync_due;
  logic        bx_end, pat_nz, push, pop, drop;
  logic [3:0]  pat_full;
  logic [15:0] frame_d;
  logic        frame_is_sync_d;
  trig_ent_t   head;

  assign xfer     = fvalid_q & frame_ready;
  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign q_empty  = (wr_ptr_q == rd_ptr_q);
  assign q_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign sync_due = (sync_cnt_q == 8'(SYNC_INTERVAL));
  assign head     = fifo_q[rd_ptr_q[AW-1:0]];

  // The BX pattern includes this cycle's hit in the bit-3 slot.
  assign pat_full = {trig, pat_q[2:0]};
  assign bx_end   = (phase_q == 2'd3);
  assign pat_nz   = bx_end & (|pat_full);

  assign pop  = xfer & ~sync_due & ~q_empty;
  // A pop on the same edge frees a slot, so a push into a full queue still lands.
  assign push = pat_nz & (~q_full | pop);
  assign drop = pat_nz & q_full & ~pop;

  // Commands only go when neither a sync nor a queued trigger is waiting.
  assign cmd_ready = xfer & ~sync_due & q_empty & cmd_valid;

  always_comb begin
    frame_d         = NOOP_WORD;
    frame_is_sync_d = 1'b0;
    if (sync_due) begin
      frame_d         = SYNC_WORD;
      frame_is_sync_d = 1'b1;
    end else if (!q_empty) begin
      frame_d = {4'hE, head.pat, head.tag};
    end else if (cmd_valid) begin
      frame_d = cmd_data;
    end
  end

  always_ff @(posedge clk160) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= '{pat: pat_full, tag: tag_q};
  end

  always_ff @(posedge clk160 or negedge rst) begin
    if (!rst) begin
      phase_q    <= 2'd0;
      pat_q      <= 4'd0;
      tag_q      <= 8'd0;
      drop_q     <= 8'd0;
      sync_cnt_q <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fvalid_q   <= 1'b0;
      fdata_q    <= SYNC_WORD;
    end else begin
      phase_q  <= phase_q + 2'd1;
      fvalid_q <= 1'b1;
      if (bx_end) pat_q <= 4'd0;
      else        pat_q[phase_q] <= trig;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        tag_q    <= tag_q + 8'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      // Non-sync frames are counted as they enter the output register, so the
      // count reaches SYNC_INTERVAL exactly as the last of them is taken and the
      // sync goes next. A non-sync load implies the count is below the limit,
      // which keeps it saturated at SYNC_INTERVAL.
      if (xfer) begin
        fdata_q <= frame_d;
        if (frame_is_sync_d) sync_cnt_q <= 8'd0;
        else                 sync_cnt_q <= sync_cnt_q + 8'd1;
      end
    end
  end

  assign frame_valid   = fvalid_q;
  assign frame_data    = fdata_q;
  assign bx_phase      = phase_q;
  assign trig_drop_cnt = drop_q;

endmodule
